channel_interleaver_pp: RTL

//   Parametrised, double-buffered channel serializer for the dataflow path.

---
 rtl/dataflow_pkg.sv | 11 +
 rtl/stream_vec_slot.sv | 42 ++++
 rtl/channel_interleaver_pp.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dataflow_pkg.sv
// Shared definitions for the dataflow path: default sample width and a
// clog2 helper that never returns zero (safe for 1-entry ranges).
package dataflow_pkg;

    localparam int DF_DATA_WIDTH = 16;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_vec_slot.sv
// One vector storage slot: holds a full channel vector with its captured
// channel count and last flag. load takes priority over clear.
module stream_vec_slot
    import dataflow_pkg::*;
#(
    parameter int DATA_WIDTH   = DF_DATA_WIDTH,
    parameter int NUM_CHANNELS = 8,
    parameter int CNT_W        = safe_clog2(NUM_CHANNELS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic                               clear,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0]                   load_cnt,
    input  logic                               load_last,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
    output logic [CNT_W-1:0]                   cnt,
    output logic                               last,
    output logic                               full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    // Payload is only meaningful while full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
            cnt  <= load_cnt;
            last <= load_last;
        end
    end

endmodule

// File: rtl/channel_interleaver_pp.sv
// Double-buffered channel serializer: parallel sample vectors in, one channel
// per beat out, with channel tag, per-vector last and end-of-packet framing.
module channel_interleaver_pp
    import dataflow_pkg::*;
#(
    parameter  int DATA_WIDTH   = DF_DATA_WIDTH,
    parameter  int NUM_CHANNELS = 8,
    localparam int CH_W         = safe_clog2(NUM_CHANNELS),
    localparam int CNT_W        = safe_clog2(NUM_CHANNELS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CNT_W-1:0]                   cfg_num_ch,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                               in_last,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CH_W-1:0]                    out_ch,
    output logic                               out_last,
    output logic                               out_eop,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy
);

    localparam int VEC_W = NUM_CHANNELS * DATA_WIDTH;

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
        if (c == '0 || int'(c) > NUM_CHANNELS) begin
            return CNT_W'(NUM_CHANNELS);
        end
        return c;
    endfunction

    logic [VEC_W-1:0]      pend_data, act_data, act_load_data;
    logic [CNT_W-1:0]      pend_cnt, act_cnt, act_load_cnt, in_cnt;
    logic                  pend_last, act_last, act_load_last;
    logic                  pend_full, act_full;
    logic [CH_W-1:0]       idx;
    logic                  out_adv, idx_is_last, act_retire, act_free;
    logic                  pend_move, accept, act_from_in, pend_load, act_load;
    logic [DATA_WIDTH-1:0] sel_sample;

    assign in_cnt      = clamp_cnt(cfg_num_ch);
    assign out_adv     = !out_valid || out_ready;
    assign idx_is_last = (CNT_W'(idx) == act_cnt - CNT_W'(1));
    assign act_retire  = act_full && out_adv && idx_is_last;
    // Active counts as free in the cycle it retires, which is what keeps
    // single-channel vectors streaming without a bubble.
    assign act_free    = !act_full || act_retire;
    assign pend_move   = pend_full && act_free;

    assign in_ready    = !rst && (!pend_full || pend_move);
    assign accept      = in_valid && in_ready;
    assign act_from_in = accept && act_free && !pend_full;
    assign pend_load   = accept && !act_from_in;
    assign act_load    = pend_move || act_from_in;

    assign act_load_data = pend_move ? pend_data : in_data;
    assign act_load_cnt  = pend_move ? pend_cnt  : in_cnt;
    assign act_load_last = pend_move ? pend_last : in_last;

    stream_vec_slot #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS),
        .CNT_W        (CNT_W)
    ) u_pend (
        .clk       (clk),
        .rst       (rst),
        .load      (pend_load),
        .clear     (pend_move),
        .load_data (in_data),
        .load_cnt  (in_cnt),
        .load_last (in_last),
        .data      (pend_data),
        .cnt       (pend_cnt),
        .last      (pend_last),
        .full      (pend_full)
    );

    stream_vec_slot #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS),
        .CNT_W        (CNT_W)
    ) u_act (
        .clk       (clk),
        .rst       (rst),
        .load      (act_load),
        .clear     (act_retire),
        .load_data (act_load_data),
        .load_cnt  (act_load_cnt),
        .load_last (act_load_last),
        .data      (act_data),
        .cnt       (act_cnt),
        .last      (act_last),
        .full      (act_full)
    );

    assign sel_sample = act_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (act_retire || act_load) begin
            idx <= '0;
        end else if (out_adv && act_full) begin
            idx <= idx + CH_W'(1);
        end
    end

    // Output stage: advances whenever empty or its beat is being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (out_adv) begin
            if (act_full) begin
                out_valid <= 1'b1;
                out_data  <= sel_sample;
                out_ch    <= idx;
                out_last  <= idx_is_last;
                out_eop   <= idx_is_last && act_last;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = act_full || pend_full || out_valid;

endmodule
